spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 target, LSB first: decodes [dir][address][data words...] frames into
// register write strobes and read requests, shifting read data back out on MISO.
module spi_slave #(
   parameter int unsigned DATA_BYTE   = 1,
   parameter int unsigned ADDR_BYTE   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_cs_n,
   input  logic                   i_sclk,
   input  logic                   i_mosi,
   output logic                   o_miso,
   output logic                   o_miso_oe,
   output logic                   o_wr_vld,
   output logic [8*ADDR_BYTE-1:0] o_wr_addr,
   output logic [8*DATA_BYTE-1:0] o_wr_data,
   output logic                   o_rd_req,
   output logic [8*ADDR_BYTE-1:0] o_rd_addr,
   input  logic [8*DATA_BYTE-1:0] i_rd_data,
   output logic                   o_frm_err,
   output logic                   o_busy
);

   localparam int unsigned DW    = 8 * DATA_BYTE;
   localparam int unsigned AW    = 8 * ADDR_BYTE;
   localparam int unsigned MAX_W = (AW > DW) ? AW : DW;
   localparam int unsigned CW    = $clog2(MAX_W);

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StDir  = 4'b0010,
      StAddr = 4'b0100,
      StData = 4'b1000
   } state_e;

   logic [SYNC_STAGES-1:0] cs_pipe, sclk_pipe, mosi_pipe;
   logic                   sclk_dly;
   logic                   cs_sync, sclk_sync, mosi_sync;
   logic                   rise_ev, fall_ev;

   state_e          state_q, state_d;
   logic            dir_q, dir_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [AW-1:0]   addr_sr_q, addr_sr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_sr_q, data_sr_d;
   logic [DW-1:0]   tx_sr_q, tx_sr_d;
   logic            ld_q, ld_d;
   logic            wr_vld_q, wr_vld_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic            rd_req_q, rd_req_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            frm_err_q, frm_err_d;

   // cs synchronizer resets to "deselected" so reset never starts a frame by itself
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_pipe   <= '1;
         sclk_pipe <= '0;
         mosi_pipe <= '0;
         sclk_dly  <= 1'b0;
      end else begin
         cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], i_cs_n};
         sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], i_sclk};
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], i_mosi};
         sclk_dly  <= sclk_pipe[SYNC_STAGES-1];
      end
   end

   assign cs_sync   = cs_pipe[SYNC_STAGES-1];
   assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
   assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
   assign rise_ev   = sclk_sync & ~sclk_dly;
   assign fall_ev   = ~sclk_sync & sclk_dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         dir_q     <= 1'b0;
         bit_cnt_q <= '0;
         addr_sr_q <= '0;
         addr_q    <= '0;
         data_sr_q <= '0;
         tx_sr_q   <= '0;
         ld_q      <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         frm_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         bit_cnt_q <= bit_cnt_d;
         addr_sr_q <= addr_sr_d;
         addr_q    <= addr_d;
         data_sr_q <= data_sr_d;
         tx_sr_q   <= tx_sr_d;
         ld_q      <= ld_d;
         wr_vld_q  <= wr_vld_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_req_q  <= rd_req_d;
         rd_addr_q <= rd_addr_d;
         frm_err_q <= frm_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      bit_cnt_d = bit_cnt_q;
      addr_sr_d = addr_sr_q;
      addr_d    = addr_q;
      data_sr_d = data_sr_q;
      tx_sr_d   = tx_sr_q;
      ld_d      = rd_req_q;
      wr_vld_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_req_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      frm_err_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            bit_cnt_d = '0;
            if (!cs_sync) state_d = StDir;
         end
         StDir: begin
            if (cs_sync) begin
               state_d = StIdle;
            end else if (rise_ev) begin
               dir_d     = mosi_sync;
               bit_cnt_d = '0;
               state_d   = StAddr;
            end
         end
         StAddr: begin
            if (cs_sync) begin
               state_d   = StIdle;
               frm_err_d = 1'b1;
            end else if (rise_ev) begin
               addr_sr_d = {mosi_sync, addr_sr_q[AW-1:1]};
               if (bit_cnt_q == CW'(AW - 1)) begin
                  addr_d    = addr_sr_d;
                  bit_cnt_d = '0;
                  state_d   = StData;
                  if (!dir_q) begin
                     rd_req_d  = 1'b1;
                     rd_addr_d = addr_sr_d;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         end
         StData: begin
            if (cs_sync) begin
               state_d   = StIdle;
               frm_err_d = (bit_cnt_q != '0);
            end else if (dir_q) begin
               if (rise_ev) begin
                  data_sr_d = {mosi_sync, data_sr_q[DW-1:1]};
                  if (bit_cnt_q == CW'(DW - 1)) begin
                     wr_vld_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = data_sr_d;
                     addr_d    = addr_q + AW'(1);
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
            end else begin
               // bit 0 of each word is presented at load time, so no shift before it
               if (fall_ev && bit_cnt_q != '0) tx_sr_d = tx_sr_q >> 1;
               if (rise_ev) begin
                  if (bit_cnt_q == CW'(DW - 1)) begin
                     addr_d    = addr_q + AW'(1);
                     bit_cnt_d = '0;
                     rd_req_d  = 1'b1;
                     rd_addr_d = addr_q + AW'(1);
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (ld_q) tx_sr_d = i_rd_data;
   end

   assign o_busy    = (state_q != StIdle);
   assign o_miso_oe = (state_q == StData) & ~dir_q & ~cs_sync;
   assign o_miso    = o_miso_oe & tx_sr_q[0];
   assign o_wr_vld  = wr_vld_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = wr_data_q;
   assign o_rd_req  = rd_req_q;
   assign o_rd_addr = rd_addr_q;
   assign o_frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: an 8/8 instance for write/read/abort/reset frames and a
// 16-bit-data instance driven at the minimum sclk half period.
module tb_spi_slave;

   localparam int SYNC     = 2;
   localparam int HALF     = 6;
   localparam int HALF_MIN = SYNC + 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs1_n = 1'b1;
   logic        cs2_n = 1'b1;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic [7:0]  rd_data = '0;
   logic [15:0] rd_data2 = '0;

   logic        o_miso, o_miso_oe, o_wr_vld, o_rd_req, o_frm_err, o_busy;
   logic [7:0]  o_wr_addr, o_wr_data, o_rd_addr;
   logic        miso2, miso_oe2, wr_vld2, rd_req2, frm_err2, busy2;
   logic [7:0]  wr_addr2, rd_addr2;
   logic [15:0] wr_data2;

   spi_slave #(.DATA_BYTE(1), .ADDR_BYTE(1), .SYNC_STAGES(SYNC)) u_dut (
      .clk(clk), .rst(rst), .i_cs_n(cs1_n), .i_sclk(sclk), .i_mosi(mosi),
      .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_wr_vld(o_wr_vld),
      .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_req(o_rd_req),
      .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .o_frm_err(o_frm_err), .o_busy(o_busy)
   );

   spi_slave #(.DATA_BYTE(2), .ADDR_BYTE(1), .SYNC_STAGES(SYNC)) u_dut16 (
      .clk(clk), .rst(rst), .i_cs_n(cs2_n), .i_sclk(sclk), .i_mosi(mosi),
      .o_miso(miso2), .o_miso_oe(miso_oe2), .o_wr_vld(wr_vld2),
      .o_wr_addr(wr_addr2), .o_wr_data(wr_data2), .o_rd_req(rd_req2),
      .o_rd_addr(rd_addr2), .i_rd_data(rd_data2), .o_frm_err(frm_err2), .o_busy(busy2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   logic [15:0] wr_q[$];
   logic [23:0] wr2_q[$];
   logic [7:0]  rdreq_q[$];
   int          frm_cnt = 0;
   int          frm2_cnt = 0;
   logic [7:0]  rd_seen;

   function automatic logic [7:0] rd_model(input logic [7:0] a);
      case (a)
         8'h40:   return 8'h3C;
         8'h41:   return 8'hC3;
         default: return a ^ 8'h5A;
      endcase
   endfunction

   always @(negedge clk) begin
      if (o_wr_vld) begin
         if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
         else check("wr_addr_data", {o_wr_addr, o_wr_data}, wr_q.pop_front());
      end
      if (o_rd_req) begin
         if (rdreq_q.size() == 0) check("rdreq_unexpected", 32'd1, 32'd0);
         else check("rd_addr", o_rd_addr, rdreq_q.pop_front());
      end
      if (wr_vld2) begin
         if (wr2_q.size() == 0) check("wr2_unexpected", 32'd1, 32'd0);
         else check("wr2_addr_data", {wr_addr2, wr_data2}, wr2_q.pop_front());
      end
      if (rd_req2 || miso_oe2 || miso2) check("dut16_read_side", 32'd1, 32'd0);
      if (o_frm_err) frm_cnt++;
      if (frm_err2) frm2_cnt++;
   end

   // Register file responds with data valid one clock after the request cycle
   always begin
      @(negedge clk);
      if (o_rd_req) begin
         rd_seen = o_rd_addr;
         @(posedge clk);
         #1 rd_data = rd_model(rd_seen);
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input int half,
                            output logic [31:0] miso_v, output int oe_n);
      miso_v = '0;
      oe_n   = 0;
      for (int i = 0; i < n; i++) begin
         mosi = v[i];
         wait_clks(half);
         sclk      = 1'b1;
         miso_v[i] = o_miso;
         oe_n     += int'(o_miso_oe);
         wait_clks(half);
         sclk = 1'b0;
      end
   endtask

   task automatic write1(input logic [7:0] addr, input logic [23:0] words, input int n);
      logic [31:0] mv;
      int          oe;
      cs1_n = 1'b0;
      wait_clks(HALF);
      send_bits(32'd1, 1, HALF, mv, oe);
      check("busy_in_frame", {31'd0, o_busy}, 32'd1);
      send_bits(32'(addr), 8, HALF, mv, oe);
      for (int w = 0; w < n; w++) begin
         wr_q.push_back({addr + 8'(w), words[8*w +: 8]});
         send_bits(32'(words[8*w +: 8]), 8, HALF, mv, oe);
      end
      wait_clks(HALF);
      cs1_n = 1'b1;
      wait_clks(12);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {o_miso, o_miso_oe, o_wr_vld, o_rd_req, o_frm_err, o_busy,
                  o_wr_addr, o_wr_data, o_rd_addr}, 32'd0);
   endtask

   initial begin
      logic [31:0] mv;
      int          oe;
      int          frm0;
      int          k;

      wait_clks(3);
      check_all_zero("reset_outputs");
      rst = 1'b0;
      wait_clks(5);

      frm0 = frm_cnt;
      write1(8'h12, 24'h0000A5, 1);
      check("single_wr_drained", wr_q.size(), 0);
      check("single_frm_err", frm_cnt - frm0, 0);
      check("single_busy_end", {31'd0, o_busy}, 32'd0);

      write1(8'hFE, 24'h332211, 3);
      check("burst_wr_drained", wr_q.size(), 0);
      check("burst_frm_err", frm_cnt - frm0, 0);

      cs1_n = 1'b0;
      wait_clks(HALF);
      send_bits(32'd0, 1, HALF, mv, oe);
      rdreq_q.push_back(8'h40);
      send_bits(32'h40, 8, HALF, mv, oe);
      check("rd_oe_in_addr", oe, 0);
      rdreq_q.push_back(8'h41);
      send_bits(32'd0, 8, HALF, mv, oe);
      check("rd_word0", mv, 32'h3C);
      check("rd_oe_word0", oe, 8);
      rdreq_q.push_back(8'h42);
      send_bits(32'd0, 8, HALF, mv, oe);
      check("rd_word1", mv, 32'hC3);
      check("rd_oe_word1", oe, 8);
      wait_clks(HALF);
      cs1_n = 1'b1;
      wait_clks(12);
      check("rd_oe_after", {31'd0, o_miso_oe}, 32'd0);
      check("rd_req_drained", rdreq_q.size(), 0);
      check("rd_frm_err", frm_cnt - frm0, 0);

      cs1_n = 1'b0;
      wait_clks(HALF);
      send_bits(32'd1, 1, HALF, mv, oe);
      send_bits(32'h33, 8, HALF, mv, oe);
      send_bits(32'hF, 4, HALF, mv, oe);
      wait_clks(HALF);
      cs1_n = 1'b1;
      k = 0;
      wait_clks(1);
      while (o_busy && k < SYNC + 1) begin
         wait_clks(1);
         k++;
      end
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      wait_clks(10);
      check("abort_frm_err", frm_cnt - frm0, 1);
      check("abort_no_wr", wr_q.size(), 0);

      frm0 = frm_cnt;
      cs1_n = 1'b0;
      wait_clks(HALF);
      send_bits(32'd0, 1, HALF, mv, oe);
      rdreq_q.push_back(8'h40);
      send_bits(32'h40, 8, HALF, mv, oe);
      send_bits(32'd0, 3, HALF, mv, oe);
      check("pre_reset_oe", {31'd0, o_miso_oe}, 32'd1);
      rst = 1'b1;
      wait_clks(1);
      check_all_zero("midread_reset");
      cs1_n = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(5);
      check("post_reset_busy", {31'd0, o_busy}, 32'd0);
      check("reset_frm_err", frm_cnt - frm0, 0);
      write1(8'h5A, 24'h000077, 1);
      check("post_reset_wr_drained", wr_q.size(), 0);

      cs2_n = 1'b0;
      wait_clks(HALF_MIN);
      send_bits(32'd1, 1, HALF_MIN, mv, oe);
      send_bits(32'h80, 8, HALF_MIN, mv, oe);
      wr2_q.push_back({8'h80, 16'hBEEF});
      send_bits(32'hBEEF, 16, HALF_MIN, mv, oe);
      wait_clks(HALF_MIN);
      cs2_n = 1'b1;
      wait_clks(12);
      check("min_timing_wr_drained", wr2_q.size(), 0);
      check("min_timing_frm_err", frm2_cnt, 0);
      check("end_rd_req_drained", rdreq_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
